// File: rtl/pll_seq_ctrl.sv
// PLL bring-up and clock-select sequencer: resets the PLL, waits for a stable lock,
// then gates, switches and ungates the downstream clock mux on request.
module pll_seq_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int LOCK_CYCLES    = 1024,
    parameter int GAP_CYCLES     = 8,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    input  logic       sel_req,
    input  logic [1:0] sel_in,
    input  logic       clr_status,
    output logic       pll_rst,
    output logic [1:0] clk_sel,
    output logic       clk_en,
    output logic       sys_rst_n,
    output logic       sel_ack,
    output logic       lock_lost,
    output logic [7:0] lost_cnt,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_PLLRST   = 3'd0,
        S_WAITLOCK = 3'd1,
        S_RUN      = 3'd2,
        S_GATE     = 3'd3,
        S_SWITCH   = 3'd4,
        S_UNGATE   = 3'd5
    } state_t;

    localparam int PH_MAX = (RST_CYCLES > GAP_CYCLES) ? RST_CYCLES : GAP_CYCLES;
    localparam int PH_W   = $clog2(PH_MAX + 1);
    localparam int LK_W   = $clog2(LOCK_CYCLES + 1);
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);

    // Terminal values are one less than the dwell length: the last cycle is the one that leaves.
    localparam logic [PH_W-1:0] RST_LAST  = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0] GAP_LAST  = PH_W'(GAP_CYCLES - 1);
    localparam logic [LK_W-1:0] LOCK_LAST = LK_W'(LOCK_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);

    state_t            r_state;
    logic              r_sync1;
    logic              r_locked_s;
    logic [2:0]        r_ctl;
    logic [1:0]        r_clk_sel;
    logic [1:0]        r_pending;
    logic              r_sel_ack;
    logic              r_ack_owed;
    logic              r_lock_lost;
    logic [7:0]        r_lost_cnt;
    logic [PH_W-1:0]   r_ph_cnt;
    logic [LK_W-1:0]   r_lock_cnt;
    logic [TO_W-1:0]   r_dwell;

    logic              w_loss;
    logic [7:0]        w_lost_inc;

    // {pll_rst, clk_en, sys_rst_n} for each state, loaded together with the state register.
    function automatic logic [2:0] f_ctl(input state_t s);
        case (s)
            S_PLLRST: f_ctl = 3'b100;
            S_RUN:    f_ctl = 3'b011;
            S_UNGATE: f_ctl = 3'b010;
            default:  f_ctl = 3'b000;
        endcase
    endfunction

    assign w_loss     = !r_locked_s && (r_state inside {S_RUN, S_GATE, S_SWITCH, S_UNGATE});
    assign w_lost_inc = (r_lost_cnt == 8'hFF) ? 8'hFF : r_lost_cnt + 8'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1     <= 1'b0;
            r_locked_s  <= 1'b0;
            r_state     <= S_PLLRST;
            r_ctl       <= 3'b100;
            r_clk_sel   <= 2'd0;
            r_pending   <= 2'd0;
            r_sel_ack   <= 1'b0;
            r_ack_owed  <= 1'b0;
            r_lock_lost <= 1'b0;
            r_lost_cnt  <= 8'd0;
            r_ph_cnt    <= '0;
            r_lock_cnt  <= '0;
            r_dwell     <= '0;
        end else begin
            r_sync1    <= pll_locked;
            r_locked_s <= r_sync1;
            r_sel_ack  <= 1'b0;

            // A loss in the same cycle as a clear must still be recorded.
            if (clr_status) begin
                r_lock_lost <= 1'b0;
                r_lost_cnt  <= 8'd0;
            end
            if (w_loss) begin
                r_lock_lost <= 1'b1;
                r_lost_cnt  <= clr_status ? 8'd1 : w_lost_inc;
            end

            case (r_state)
                S_PLLRST: begin
                    if (r_ph_cnt == RST_LAST) begin
                        r_state    <= S_WAITLOCK;
                        r_ctl      <= f_ctl(S_WAITLOCK);
                        r_ph_cnt   <= '0;
                        r_lock_cnt <= '0;
                        r_dwell    <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                S_WAITLOCK: begin
                    if (r_locked_s && r_lock_cnt == LOCK_LAST) begin
                        r_state    <= S_RUN;
                        r_ctl      <= f_ctl(S_RUN);
                        r_sel_ack  <= r_ack_owed;
                        r_ack_owed <= 1'b0;
                    end else if (r_dwell == TO_LAST) begin
                        r_state  <= S_PLLRST;
                        r_ctl    <= f_ctl(S_PLLRST);
                        r_ph_cnt <= '0;
                    end else begin
                        r_dwell    <= r_dwell + TO_W'(1);
                        r_lock_cnt <= r_locked_s ? r_lock_cnt + LK_W'(1) : '0;
                    end
                end
                S_RUN: begin
                    if (w_loss) begin
                        r_state  <= S_PLLRST;
                        r_ctl    <= f_ctl(S_PLLRST);
                        r_ph_cnt <= '0;
                    end else if (sel_req && !r_sel_ack) begin
                        if (sel_in == r_clk_sel) begin
                            r_sel_ack <= 1'b1;
                        end else begin
                            r_pending <= sel_in;
                            r_state   <= S_GATE;
                            r_ctl     <= f_ctl(S_GATE);
                            r_ph_cnt  <= '0;
                        end
                    end
                end
                S_GATE, S_SWITCH, S_UNGATE: begin
                    // An aborted switch still commits the new select and owes the requester an ack.
                    if (w_loss) begin
                        r_clk_sel  <= r_pending;
                        r_ack_owed <= 1'b1;
                        r_state    <= S_PLLRST;
                        r_ctl      <= f_ctl(S_PLLRST);
                        r_ph_cnt   <= '0;
                    end else if (r_state == S_SWITCH) begin
                        r_state  <= S_UNGATE;
                        r_ctl    <= f_ctl(S_UNGATE);
                        r_ph_cnt <= '0;
                    end else if (r_ph_cnt == GAP_LAST) begin
                        if (r_state == S_GATE) begin
                            r_clk_sel <= r_pending;
                            r_state   <= S_SWITCH;
                            r_ctl     <= f_ctl(S_SWITCH);
                        end else begin
                            r_sel_ack <= 1'b1;
                            r_state   <= S_RUN;
                            r_ctl     <= f_ctl(S_RUN);
                        end
                        r_ph_cnt <= '0;
                    end else begin
                        r_ph_cnt <= r_ph_cnt + PH_W'(1);
                    end
                end
                default: begin
                    r_state  <= S_PLLRST;
                    r_ctl    <= f_ctl(S_PLLRST);
                    r_ph_cnt <= '0;
                end
            endcase
        end
    end

    assign pll_rst   = r_ctl[2];
    assign clk_en    = r_ctl[1];
    assign sys_rst_n = r_ctl[0];
    assign clk_sel   = r_clk_sel;
    assign sel_ack   = r_sel_ack;
    assign lock_lost = r_lock_lost;
    assign lost_cnt  = r_lost_cnt;
    assign state     = r_state;

endmodule

// File: tb/tb_pll_seq_ctrl.sv
// Bench for pll_seq_ctrl with shortened dwell parameters: directed vector table,
// hand sequences for aborts/saturation/timeouts, and random traffic against a reference model.
module tb_pll_seq_ctrl;

    localparam int RST_C  = 4;
    localparam int LOCK_C = 10;
    localparam int GAP_C  = 3;
    localparam int TO_C   = 40;

    localparam int P_RST  = 0;
    localparam int P_WAIT = 1;
    localparam int P_RUN  = 2;
    localparam int P_GATE = 3;
    localparam int P_SW   = 4;
    localparam int P_UNG  = 5;

    logic       clk = 1'b0;
    logic       rst_n, pll_locked, sel_req, clr_status;
    logic [1:0] sel_in;
    logic       pll_rst, clk_en, sys_rst_n, sel_ack, lock_lost;
    logic [1:0] clk_sel;
    logic [7:0] lost_cnt;
    logic [2:0] state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    pll_seq_ctrl #(
        .RST_CYCLES(RST_C), .LOCK_CYCLES(LOCK_C), .GAP_CYCLES(GAP_C), .TIMEOUT_CYCLES(TO_C)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .sel_req(sel_req), .sel_in(sel_in),
        .clr_status(clr_status), .pll_rst(pll_rst), .clk_sel(clk_sel), .clk_en(clk_en),
        .sys_rst_n(sys_rst_n), .sel_ack(sel_ack), .lock_lost(lock_lost), .lost_cnt(lost_cnt),
        .state(state)
    );

    always #5 clk = ~clk;

    // Reference model: phase plus time spent in it; lock seen through a two-deep delay queue.
    int         m_phase, m_since, m_run, m_cnt;
    logic [1:0] m_sel, m_pend;
    bit         m_ack, m_owed, m_lost;
    bit         lk_q[$];

    function automatic void model_reset();
        m_phase = P_RST; m_since = 0; m_run = 0; m_cnt = 0;
        m_sel = 2'd0; m_pend = 2'd0; m_ack = 1'b0; m_owed = 1'b0; m_lost = 1'b0;
        lk_q = '{1'b0, 1'b0};
    endfunction

    function automatic void enter(input int p);
        m_phase = p; m_since = 0; m_run = 0;
    endfunction

    function automatic void model_step();
        bit ls, loss, ack_prev;
        if (!rst_n) begin
            model_reset();
            return;
        end
        ls = lk_q.pop_front();
        lk_q.push_back(pll_locked);
        ack_prev = m_ack;
        m_ack = 1'b0;
        loss = 1'b0;
        m_since++;
        case (m_phase)
            P_RST: if (m_since == RST_C) enter(P_WAIT);
            P_WAIT: begin
                m_run = ls ? m_run + 1 : 0;
                if (m_run == LOCK_C) begin
                    enter(P_RUN); m_ack = m_owed; m_owed = 1'b0;
                end else if (m_since == TO_C) begin
                    enter(P_RST);
                end
            end
            P_RUN: begin
                if (!ls) begin
                    loss = 1'b1; enter(P_RST);
                end else if (sel_req && !ack_prev) begin
                    if (sel_in == m_sel) m_ack = 1'b1;
                    else begin m_pend = sel_in; enter(P_GATE); end
                end
            end
            default: begin
                if (!ls) begin
                    loss = 1'b1; m_sel = m_pend; m_owed = 1'b1; enter(P_RST);
                end else if (m_phase == P_GATE && m_since == GAP_C) begin
                    m_sel = m_pend; enter(P_SW);
                end else if (m_phase == P_SW) begin
                    enter(P_UNG);
                end else if (m_phase == P_UNG && m_since == GAP_C) begin
                    enter(P_RUN); m_ack = 1'b1;
                end
            end
        endcase
        if (clr_status) begin m_lost = 1'b0; m_cnt = 0; end
        if (loss) begin m_lost = 1'b1; m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255; end
    endfunction

    function automatic logic [17:0] pack(input logic [2:0] st, input logic prst, input logic [1:0] csel,
                                         input logic en, input logic srst, input logic ack,
                                         input logic lost, input logic [7:0] cnt);
        return {st, prst, csel, en, srst, ack, lost, cnt};
    endfunction

    function automatic logic [17:0] dut_vec();
        return {state, pll_rst, clk_sel, clk_en, sys_rst_n, sel_ack, lock_lost, lost_cnt};
    endfunction

    function automatic logic [17:0] model_vec();
        return pack(3'(m_phase), m_phase == P_RST, m_sel, m_phase == P_RUN || m_phase == P_UNG,
                    m_phase == P_RUN, m_ack, m_lost, 8'(m_cnt));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_assert++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %0h, required %0h", nm, cyc, act, req);
        end
    endtask

    // One clock: model and DUT both advance on the rising edge, outputs compared on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cyc++;
        chk("model", 32'(dut_vec()), 32'(model_vec()));
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wait_run(input string nm);
        int n;
        n = 0;
        while (state != 3'd2 && n < 200) begin tick(); n++; end
        chk(nm, 32'(state), 32'd2);
    endtask

    typedef struct {
        logic pl, sreq; logic [1:0] sin; logic clr; int cyc_n; logic [17:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic pl, input logic sreq, input logic [1:0] sin,
                                input logic clr, input int n, input logic [17:0] e);
        vec_t v;
        v.pl = pl; v.sreq = sreq; v.sin = sin; v.clr = clr; v.cyc_n = n; v.exp = e;
        return v;
    endfunction

    vec_t vecs[$];

    initial begin
        bit seen_ack;
        int n, drop_left, rst_left;
        bit req_on;

        // Boot, switch to 2, same-select 2, one-cycle lock drop in RUN, status clear.
        vecs.push_back(mk(1, 0, 0, 0, 3, pack(0, 1, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 1, pack(1, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 9, pack(1, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 0, 0, 1, pack(2, 0, 0, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 2, 0, 1, pack(3, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 2, 0, 2, pack(3, 0, 0, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 2, 0, 1, pack(4, 0, 2, 0, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 2, 0, 1, pack(5, 0, 2, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 2, 0, 2, pack(5, 0, 2, 1, 0, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 2, 0, 1, pack(2, 0, 2, 1, 1, 1, 0, 0)));
        vecs.push_back(mk(1, 0, 2, 0, 1, pack(2, 0, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 1, 2, 0, 1, pack(2, 0, 2, 1, 1, 1, 0, 0)));
        vecs.push_back(mk(1, 0, 2, 0, 1, pack(2, 0, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(0, 0, 2, 0, 1, pack(2, 0, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 2, 0, 1, pack(2, 0, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 2, 0, 1, pack(0, 1, 2, 0, 0, 0, 1, 1)));
        vecs.push_back(mk(1, 0, 2, 0, 3, pack(0, 1, 2, 0, 0, 0, 1, 1)));
        vecs.push_back(mk(1, 0, 2, 0, 1, pack(1, 0, 2, 0, 0, 0, 1, 1)));
        vecs.push_back(mk(1, 0, 2, 0, 9, pack(1, 0, 2, 0, 0, 0, 1, 1)));
        vecs.push_back(mk(1, 0, 2, 0, 1, pack(2, 0, 2, 1, 1, 0, 1, 1)));
        vecs.push_back(mk(1, 0, 2, 1, 1, pack(2, 0, 2, 1, 1, 0, 0, 0)));
        vecs.push_back(mk(1, 0, 2, 0, 1, pack(2, 0, 2, 1, 1, 0, 0, 0)));

        rst_n = 1'b0; pll_locked = 1'b1; sel_req = 1'b0; sel_in = 2'd0; clr_status = 1'b0;
        model_reset();
        tickn(3);
        chk("reset_state", 32'(dut_vec()), 32'(pack(0, 1, 0, 0, 0, 0, 0, 0)));
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            pll_locked = vecs[i].pl; sel_req = vecs[i].sreq; sel_in = vecs[i].sin;
            clr_status = vecs[i].clr;
            tickn(vecs[i].cyc_n);
            chk($sformatf("vec%0d", i), 32'(dut_vec()), 32'(vecs[i].exp));
        end

        // Lock lost while gated with select 3 pending.
        sel_req = 1'b1; sel_in = 2'd3;
        tick();
        chk("gate_entry", 32'(state), 32'd3);
        pll_locked = 1'b0;
        tickn(3);
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_clk_sel", 32'(clk_sel), 32'd3);
        chk("abort_lost_cnt", 32'(lost_cnt), 32'd1);
        chk("abort_lock_lost", 32'(lock_lost), 32'd1);
        pll_locked = 1'b1;
        wait_run("abort_relock");
        chk("abort_ack", 32'(sel_ack), 32'd1);
        chk("abort_run_sel", 32'(clk_sel), 32'd3);
        sel_req = 1'b0;
        tick();
        chk("abort_ack_end", 32'(sel_ack), 32'd0);

        // Clear coinciding with a loss: the loss wins and the count restarts at 1.
        pll_locked = 1'b0;
        tickn(2);
        clr_status = 1'b1;
        tick();
        clr_status = 1'b0;
        chk("clr_loss_cnt", 32'(lost_cnt), 32'd1);
        chk("clr_loss_flag", 32'(lock_lost), 32'd1);
        pll_locked = 1'b1;
        tickn(2);
        wait_run("clr_loss_relock");

        // Enough losses to saturate the counter.
        for (int i = 0; i < 256; i++) begin
            pll_locked = 1'b0;
            tick();
            pll_locked = 1'b1;
            tickn(2);
            wait_run("sat_relock");
        end
        chk("sat_cnt", 32'(lost_cnt), 32'd255);

        // Reset in the middle of a switch drops the request and never acks it.
        sel_req = 1'b1; sel_in = 2'd1;
        tick();
        chk("rst_gate_entry", 32'(state), 32'd3);
        rst_n = 1'b0; sel_req = 1'b0;
        #1;
        chk("async_reset", 32'(dut_vec()), 32'(pack(0, 1, 0, 0, 0, 0, 0, 0)));
        tickn(2);
        rst_n = 1'b1;
        seen_ack = 1'b0; n = 0;
        while (state != 3'd2 && n < 200) begin
            tick(); n++;
            if (sel_ack) seen_ack = 1'b1;
        end
        chk("rst_reboot", 32'(state), 32'd2);
        chk("rst_no_ack", 32'(seen_ack), 32'd0);
        chk("rst_clk_sel", 32'(clk_sel), 32'd0);

        // PLL never locks: PLLRST and WAITLOCK alternate on the timeout, no loss recorded.
        rst_n = 1'b0; pll_locked = 1'b0;
        tickn(2);
        rst_n = 1'b1;
        tickn(RST_C);
        chk("nolock_wait1", 32'(state), 32'd1);
        tickn(TO_C);
        chk("nolock_retry1", 32'(state), 32'd0);
        tickn(RST_C);
        chk("nolock_wait2", 32'(state), 32'd1);
        tickn(TO_C);
        chk("nolock_retry2", 32'(dut_vec()), 32'(pack(0, 1, 0, 0, 0, 0, 0, 0)));

        // Random traffic with a well-behaved requester.
        rst_n = 1'b0; pll_locked = 1'b1;
        tickn(2);
        rst_n = 1'b1;
        drop_left = 0; rst_left = 0; req_on = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (drop_left > 0) begin
                pll_locked = 1'b0; drop_left--;
            end else begin
                pll_locked = 1'b1;
                n = int'($urandom_range(0, 999));
                if (n < 8) drop_left = int'($urandom_range(1, 4));
                else if (n < 10) drop_left = int'($urandom_range(30, 70));
            end
            if (req_on && sel_ack) begin
                req_on = 1'b0; sel_req = 1'b0;
            end else if (!req_on && $urandom_range(0, 9) == 0) begin
                req_on = 1'b1; sel_req = 1'b1; sel_in = 2'($urandom_range(0, 3));
            end
            clr_status = ($urandom_range(0, 59) == 0);
            if (rst_left > 0) begin
                rst_left--;
                rst_n = (rst_left == 0);
            end else if ($urandom_range(0, 1999) == 0) begin
                rst_left = 2; rst_n = 1'b0;
            end
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
